// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the four-digit seven-segment scan driver:
//   - scan_state_t : which digit position is currently being driven
//   - SEG_*        : active-low cathode patterns ordered {g,f,e,d,c,b,a}
package seg7_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD to seven-segment decoder. Values 10-15 are not valid
// BCD and are shown as a dash so a corrupted digit is visible on the panel.
// Ports:
//   value : 4-bit digit value
//   seg   : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (value)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10, 4'd11, 4'd12,
      4'd13, 4'd14, 4'd15: seg = SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes four BCD digits onto a common-anode seven-segment display.
// Each digit is held for REFRESH_DIV clocks; a full S0..S3 sweep is a frame.
// The digit inputs are captured once per frame so the display never tears.
// Optional leading-zero blanking and whole-display blinking are supported.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   dig3..dig0         : BCD digits, dig3 is leftmost
//   blank_lz           : blank leading zeros on digits 3 and 2
//   blink_en           : blink the whole display
//   an                 : active-low anodes, an[i] selects digit i
//   seg                : active-low cathodes {g,f,e,d,c,b,a}
//   dp                 : active-low decimal point (lit after digit 2)
//   frame_tick         : one-cycle pulse marking each frame snapshot
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dig3,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRE_W-1:0] presc;
  logic             tc;
  scan_state_t      state, next_state;
  logic [3:0]       snap [4];
  logic             blink_off;
  logic [FR_W-1:0]  frame_cnt;
  logic             frame_evt;

  logic [3:0] cur_val;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;
  logic       blank;

  assign tc        = (presc == PRE_W'(REFRESH_DIV - 1));
  assign frame_evt = tc && (state == S3);

  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= next_state;
  end

  // Next scan state, digit select and per-digit blanking. Blinking is gated
  // by the live blink_en so dropping it restores scanning immediately.
  always_comb begin
    next_state = state;
    cur_val    = snap[0];
    an_next    = 4'b1110;
    dp_next    = 1'b1;
    blank      = 1'b0;
    case (state)
      S0: begin
        an_next = 4'b1110;
        cur_val = snap[0];
        if (tc) next_state = S1;
      end
      S1: begin
        an_next = 4'b1101;
        cur_val = snap[1];
        if (tc) next_state = S2;
      end
      S2: begin
        an_next = 4'b1011;
        cur_val = snap[2];
        dp_next = 1'b0;
        blank   = blank_lz && (snap[3] == 4'd0) && (snap[2] == 4'd0);
        if (tc) next_state = S3;
      end
      S3: begin
        an_next = 4'b0111;
        cur_val = snap[3];
        blank   = blank_lz && (snap[3] == 4'd0);
        if (tc) next_state = S0;
      end
      default: next_state = S0;
    endcase
    if (blank || (blink_en && blink_off)) an_next = 4'b1111;
  end

  seg7_decode u_decode (
    .value (cur_val),
    .seg   (seg_next)
  );

  // Prescaler, frame snapshot, blink phase and the registered output pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      for (int i = 0; i < 4; i++) snap[i] <= 4'd0;
      blink_off  <= 1'b0;
      frame_cnt  <= '0;
      an         <= 4'b1110;
      seg        <= SEG_0;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      presc <= tc ? '0 : presc + PRE_W'(1);
      if (frame_evt) begin
        snap[3] <= dig3;
        snap[2] <= dig2;
        snap[1] <= dig1;
        snap[0] <= dig0;
      end
      if (!blink_en) begin
        blink_off <= 1'b0;
        frame_cnt <= '0;
      end else if (frame_evt) begin
        if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          frame_cnt <= frame_cnt + FR_W'(1);
        end
      end
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= frame_evt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Randomized and directed stimulus for seg7_scan_driver with a time-based
// reference model. Expected pin values are queued as stimulus is applied and
// a negedge monitor pops and compares them against the DUT.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dig3 = 4'd0, dig2 = 4'd0, dig1 = 4'd0, dig0 = 4'd0;
  logic       blank_lz = 1'b0;
  logic       blink_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model state: edges since reset release, captured digits and
  // the number of frames seen during the current blink_en run.
  int         m = 0;
  logic [3:0] msnap [4];
  int         bcount = 0;

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dig3       (dig3),
    .dig2       (dig2),
    .dig1       (dig1),
    .dig0       (dig0),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_decode(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int model_digit();
    return (m / DIV) % 4;
  endfunction

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("an",         {3'b000, an},         {3'b000, e.an});
    cmp("seg",        seg,                  e.seg);
    cmp("dp",         {6'd0, dp},           {6'd0, e.dp});
    cmp("frame_tick", {6'd0, frame_tick},   {6'd0, e.ft});
  endtask

  // Drive one cycle of inputs, compute the pins expected after the coming
  // edge from the model, and queue them once the edge has happened.
  task automatic applyStimulus(input bit rst, input logic [3:0] d3, input logic [3:0] d2,
                               input logic [3:0] d1, input logic [3:0] d0,
                               input bit blz, input bit bl);
    exp_t       e;
    int         k;
    bit         frame, off, blank;
    logic [3:0] onehot;
    reset = rst; dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0;
    blank_lz = blz; blink_en = bl;
    if (rst) begin
      e.an = 4'b1110; e.seg = 7'b1000000; e.dp = 1'b1; e.ft = 1'b0;
      m = 0; bcount = 0;
      for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
    end else begin
      k      = model_digit();
      frame  = (m % FRAME) == FRAME - 1;
      off    = bl && (((bcount / BF) % 2) == 1);
      blank  = blz && ((k == 3 && msnap[3] == 4'd0) ||
                       (k == 2 && msnap[3] == 4'd0 && msnap[2] == 4'd0));
      onehot = 4'b0001 << k;
      e.an   = (off || blank) ? 4'b1111 : ~onehot;
      e.seg  = ref_decode(msnap[k]);
      e.dp   = (k != 2);
      e.ft   = frame;
      if (frame) begin
        msnap[3] = d3; msnap[2] = d2; msnap[1] = d1; msnap[0] = d0;
      end
      bcount = bl ? bcount + (frame ? 1 : 0) : 0;
      m++;
    end
    @(posedge clk);
    exp_q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic run(input int n, input logic [3:0] d3, input logic [3:0] d2,
                     input logic [3:0] d1, input logic [3:0] d0, input bit blz, input bit bl);
    repeat (n) applyStimulus(1'b0, d3, d2, d1, d0, blz, bl);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=reached cycle=%0d", name, cyc);
  endtask

  // Monitor: one set of expected pins per cycle, checked away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int         n;
    logic [3:0] r3, r2, r1, r0;
    bit         rb, rl;
    for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
    @(posedge clk); #1;

    $display("[TB] reset hold");
    repeat (3) applyStimulus(1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0);

    $display("[TB] basic scan 4,3,0,7");
    run(2 * FRAME + 2, 4'd4, 4'd3, 4'd0, 4'd7, 1'b0, 1'b0);

    $display("[TB] leading-zero blanking");
    run(2 * FRAME, 4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
    run(2 * FRAME, 4'd0, 4'd1, 4'd5, 4'd9, 1'b1, 1'b0);

    $display("[TB] snapshot tearing and dash");
    run(FRAME, 4'd4, 4'd3, 4'd0, 4'd7, 1'b0, 1'b0);
    n = 0;
    while (model_digit() != 2 && n < FRAME) begin
      applyStimulus(1'b0, 4'd4, 4'd3, 4'd0, 4'd7, 1'b0, 1'b0);
      n++;
    end
    if (model_digit() != 2) bound_fail("wait_s2_tear");
    run(2 * FRAME, 4'd4, 4'd3, 4'd0, 4'd2, 1'b0, 1'b0);
    run(2 * FRAME, 4'd4, 4'd3, 4'd0, 4'hC, 1'b0, 1'b0);

    $display("[TB] blinking");
    run(7 * FRAME, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
    n = 0;
    while (!((((bcount / BF) % 2) == 1) && (m % FRAME) == 5) && n < 8 * FRAME) begin
      applyStimulus(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
      n++;
    end
    if (n >= 8 * FRAME) bound_fail("wait_blink_off");
    run(2 * FRAME, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);

    $display("[TB] reset during S2");
    n = 0;
    while (model_digit() != 2 && n < FRAME) begin
      applyStimulus(1'b0, 4'd6, 4'd8, 4'd2, 4'd5, 1'b0, 1'b0);
      n++;
    end
    if (model_digit() != 2) bound_fail("wait_s2_reset");
    applyStimulus(1'b1, 4'd6, 4'd8, 4'd2, 4'd5, 1'b0, 1'b0);
    run(2 * FRAME, 4'd6, 4'd8, 4'd2, 4'd5, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    r3 = 4'd0; r2 = 4'd0; r1 = 4'd0; r0 = 4'd0; rb = 1'b0; rl = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) r3 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) r2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) r1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0 && r3 > 4'd1) r3 = 4'd0;
      if ($urandom_range(0, 49) == 0) rb = ~rb;
      if ($urandom_range(0, 79) == 0) rl = ~rl;
      applyStimulus($urandom_range(0, 149) == 0, r3, r2, r1, r0, rb, rl);
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
